// File: rtl/e_mdu_if.sv
// Operand/op-code and status bundle between the E stage and the multiply/divide unit.
// The E stage owns the master side; the MDU implements the slave side.
interface e_mdu_if;
  logic [3:0]  E_MDU_Ctr;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        E_MDU_Start;
  logic        E_MDU_Busy;
  logic [31:0] E_MDU_Out;
  logic        fsm_state;

  modport master (
    output E_MDU_Ctr,
    output SrcA,
    output SrcB,
    input  E_MDU_Start,
    input  E_MDU_Busy,
    input  E_MDU_Out,
    input  fsm_state
  );

  modport slave (
    input  E_MDU_Ctr,
    input  SrcA,
    input  SrcB,
    output E_MDU_Start,
    output E_MDU_Busy,
    output E_MDU_Out,
    output fsm_state
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency mult/div, mfhi/mflo/mthi/mtlo.
// Optional accumulate ops (madd/maddu, codes 9/10) are built only when MDU_MADD_EN is defined.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi_q;
  logic [31:0]      pend_lo_q;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_madd, is_maddu;
  logic is_multi;
  logic busy;
  logic start;
  logic load;
  logic commit;

  // Op decode; reserved codes (and 9/10 without the accumulate feature) decode to nothing.
  always_comb begin
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    is_mfhi  = 1'b0;
    is_mflo  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    is_madd  = 1'b0;
    is_maddu = 1'b0;
    case (mdu.E_MDU_Ctr)
      OP_MULT:  is_mult  = 1'b1;
      OP_MULTU: is_multu = 1'b1;
      OP_DIV:   is_div   = 1'b1;
      OP_DIVU:  is_divu  = 1'b1;
      OP_MFHI:  is_mfhi  = 1'b1;
      OP_MFLO:  is_mflo  = 1'b1;
      OP_MTHI:  is_mthi  = 1'b1;
      OP_MTLO:  is_mtlo  = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  is_madd  = 1'b1;
      OP_MADDU: is_maddu = 1'b1;
`endif
      default: ;
    endcase
  end

  assign is_multi = is_mult | is_multu | is_div | is_divu | is_madd | is_maddu;

  // Handshake: Start is a combinational request, asserted when a multi-cycle op sits in E
  // and Busy is low; an op is accepted exactly on a clock edge where Start is high, and
  // Busy then stays high until the edge on which the result is committed to HI/LO.
  assign busy  = (state_q == RUN);
  assign start = is_multi & ~busy;

  // ---------------------------------------------------------------------------
  // Arithmetic. Products are formed at 64 bits on extended operands; the low
  // 64 bits of the product of sign-extended operands is the signed product.
  // ---------------------------------------------------------------------------
  logic [63:0] ext_a_s, ext_b_s, ext_a_u, ext_b_u;
  logic [63:0] prod_s, prod_u;

  assign ext_a_s = {{32{mdu.SrcA[31]}}, mdu.SrcA};
  assign ext_b_s = {{32{mdu.SrcB[31]}}, mdu.SrcB};
  assign ext_a_u = {32'd0, mdu.SrcA};
  assign ext_b_u = {32'd0, mdu.SrcB};
  assign prod_s  = ext_a_s * ext_b_s;
  assign prod_u  = ext_a_u * ext_b_u;

  logic        div_zero;
  logic [31:0] divisor;
  logic [31:0] abs_a, abs_b;
  logic [31:0] quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s;
  logic [31:0] quo_u, rem_u;

  // A zero divisor is replaced by one so the dividers never see x; the result is discarded.
  assign div_zero = (mdu.SrcB == 32'd0);
  assign divisor  = div_zero ? 32'd1 : mdu.SrcB;

  // Signed divide on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude,
  // which makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
  assign abs_a   = mdu.SrcA[31] ? (32'd0 - mdu.SrcA) : mdu.SrcA;
  assign abs_b   = divisor[31]  ? (32'd0 - divisor)  : divisor;
  assign quo_mag = abs_a / abs_b;
  assign rem_mag = abs_a % abs_b;
  assign quo_s   = (mdu.SrcA[31] ^ divisor[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = mdu.SrcA[31] ? (32'd0 - rem_mag) : rem_mag;
  assign quo_u   = mdu.SrcA / divisor;
  assign rem_u   = mdu.SrcA % divisor;

  logic [63:0] result;

  always_comb begin
    result = {hi_q, lo_q};
    if (is_mult) begin
      result = prod_s;
    end else if (is_multu) begin
      result = prod_u;
    end else if (is_div) begin
      if (!div_zero) result = {rem_s, quo_s};
    end else if (is_divu) begin
      if (!div_zero) result = {rem_u, quo_u};
    end
`ifdef MDU_MADD_EN
    else if (is_madd) begin
      result = {hi_q, lo_q} + prod_s;
    end else if (is_maddu) begin
      result = {hi_q, lo_q} + prod_u;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      if (load) begin
        pend_hi_q <= result[63:32];
        pend_lo_q <= result[31:0];
        cnt_q     <= (is_div | is_divu) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (busy) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      // Moves to HI/LO only land while idle; a move arriving during an operation is dropped.
      if (commit) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end else if (!busy) begin
        if (is_mthi) hi_q <= mdu.SrcA;
        if (is_mtlo) lo_q <= mdu.SrcA;
      end
    end
  end

  // mfhi/mflo read the architectural registers only; pending results are not bypassed.
  always_comb begin
    mdu.E_MDU_Out = 32'd0;
    if (is_mfhi)      mdu.E_MDU_Out = hi_q;
    else if (is_mflo) mdu.E_MDU_Out = lo_q;
  end

  assign mdu.E_MDU_Start = start;
  assign mdu.E_MDU_Busy  = busy;
  assign mdu.fsm_state   = state_q;

endmodule
